condicionador_botoes: RTL
=========================

# condicionador_botoes

Input conditioner that produces the game's 8-bit `botoes` bus from the raw panel pushbuttons. It synchronizes and debounces each raw button. It then emits exactly one single-cycle one-hot pulse per accepted press, so the data path always sees clean, non-repeating button events. It sits between the board pins and the `botoes` input of the memory-game top level, on the same `clock`.

## Interface

**Parameters**
- `DEBOUNCE_CICLOS`, default 50000: number of consecutive cycles a synchronized input must differ from its stable value before the stable value changes (1 ms at 50 MHz). Must be ≥ 2.
- `ATIVO_BAIXO`, default 0: when 1, raw inputs are inverted at entry (pressed = 0 on the pin).

**Ports**
- `clock`  input  1  system clock, single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `botoes_brutos`  input  8  raw, asynchronous pushbutton levels.
- `botoes`  output  8  one-hot, one-cycle pulse per accepted press; all zero otherwise.
- `pressionado`  output  1  high while a press is held (FSM in ESPERA_SOLTAR).
- `db_botao`  output  3  index of the last accepted button, for debug display.

## Operation

**Entry**
- Each bit is optionally inverted per `ATIVO_BAIXO`.
- Each bit then passes through a 2-FF synchronizer (`sinc1`, `sinc2`).

**Debounce (per bit, independent)**
- State per bit: register `estavel` and a counter of width clog2(`DEBOUNCE_CICLOS`).
- When `sinc2` == `estavel`, the counter clears to 0.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CICLOS`-1 while still differing, `estavel` takes `sinc2` on that edge and the counter clears.
- A glitch shorter than `DEBOUNCE_CICLOS` cycles never changes `estavel`.

**Selection FSM**, states OCIOSO and ESPERA_SOLTAR
- OCIOSO:
  - If any `estavel` bit is 1, select the lowest index i with `estavel`[i]=1.
  - Register `botoes` = 1<<i for one cycle, set `db_botao` = i, and go to ESPERA_SOLTAR.
  - Otherwise stay in OCIOSO with `botoes` = 0.
- ESPERA_SOLTAR:
  - `botoes` = 0.
  - When all eight `estavel` bits are 0, return to OCIOSO. Otherwise stay.
- Additional presses while in ESPERA_SOLTAR are ignored entirely. They produce no pulse, even after the first button is released, unless they are still held when the FSM re-enters OCIOSO.
- A button still held at re-entry to OCIOSO is accepted as a new press on the next cycle.

**Simultaneous events**
- Several `estavel` bits rising on the same cycle: only the lowest index is pulsed.

**Reset** (any time, including mid-debounce or mid-press)
- Synchronizers, `estavel` bits and counters clear to 0.
- FSM goes to OCIOSO.
- After reset, a button held through reset is treated as a fresh press and pulses after full debounce.

## Timing

**Reset values:** `botoes` = 8'h00, `pressionado` = 0, `db_botao` = 3'd0.

**Press latency**
- Raw bit stable high from sampling edge k gives `sinc2` high after edge k+1.
- `estavel` high after edge k+1+`DEBOUNCE_CICLOS`.
- `botoes` pulse high during the cycle after edge k+2+`DEBOUNCE_CICLOS`, for exactly one cycle.

**`pressionado`**
- Rises in the same cycle as the `botoes` pulse.
- Falls one cycle after the last `estavel` bit falls.

**Release latency:** raw low to `estavel` low is the same as press latency, 2+`DEBOUNCE_CICLOS` edges.

**Throughput and other outputs**
- Minimum spacing between two pulses is release debounce plus press debounce.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- **Shared package** `pkg_botoes`:
  - FSM state encoding (OCIOSO=1'b0, ESPERA_SOLTAR=1'b1).
  - Constant NUM_BOTOES=8.
  - A function returning the lowest-set-bit index of an 8-bit vector.
- **Sub-module** `debouncer_bit`: holds the synchronizer, counter and `estavel` for one input, parameterized by `DEBOUNCE_CICLOS`. It is instantiated NUM_BOTOES times via generate.
- **Top level**: the FSM, priority selection and output registers live in `condicionador_botoes`.

## Test plan

All scenarios use `DEBOUNCE_CICLOS`=4, `ATIVO_BAIXO`=0.

- **Basic press:** reset, then `botoes_brutos`=8'h04 held for 20 cycles. Expect `botoes`=8'h04 for exactly one cycle, 6 cycles after the first sampling edge; `pressionado`=1 and `db_botao`=2 until release plus 6 cycles.
- **Bounce rejection:** toggle bit 5 high/low with runs of 3 cycles for 30 cycles, then hold it low. Expect `botoes` to stay 8'h00 and `pressionado` to stay 0 throughout.
- **Simultaneous press:** 8'h90 applied in one cycle and held. Expect exactly one pulse 8'h10 and `db_botao`=4. Release bit 4 only, keep bit 7 held: expect no new pulse, because the FSM never left ESPERA_SOLTAR.
- **Re-arm:** press 8'h01, release fully, wait 10 cycles, press 8'h01 again. Expect two separate 8'h01 pulses and `pressionado` low between them.
- **Reset mid-press:** hold 8'h40, assert `reset` for 1 cycle after the pulse, keep 8'h40 held. Expect all outputs to be 0 on the cycle after reset, then a new 8'h40 pulse 6 cycles after reset deasserts.
- **Active-low mode:** with `ATIVO_BAIXO`=1, idle input is 8'hFF. Drive 8'hFE: expect a `botoes`=8'h01 pulse. Check that the idle 8'hFF input never produces a pulse.

Source files
------------

// File: rtl/condicionador_botoes_pkg.sv
// -----------------------------------------------------------------------------
// pkg_botoes
//
// Shared definitions for the pushbutton conditioner:
//   - NUM_BOTOES     : number of panel buttons handled in parallel
//   - estado_t       : selection FSM state encoding
//   - indice_menor() : index of the lowest set bit of an 8-bit vector
// -----------------------------------------------------------------------------
package pkg_botoes;

    localparam int unsigned NUM_BOTOES = 8;

    typedef enum logic [0:0] {
        OCIOSO        = 1'b0,
        ESPERA_SOLTAR = 1'b1
    } estado_t;

    // Lowest set bit wins. Scanning from the top means the final write is
    // the lowest index. Returns 0 for an all-zero vector; callers check for
    // that case themselves.
    function automatic logic [2:0] indice_menor(input logic [NUM_BOTOES-1:0] vetor);
        logic [2:0] indice;
        indice = 3'd0;
        for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
            if (vetor[i]) begin
                indice = 3'(i);
            end
        end
        return indice;
    endfunction

endpackage

// File: rtl/condicionador_botoes_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer_bit
//
// Synchronizes and debounces one raw button level.
//
// Ports:
//   clock   : system clock
//   reset   : synchronous, active-high reset
//   bruto   : raw asynchronous level (already polarity-corrected)
//   estavel : debounced level; changes only after DEBOUNCE_CICLOS
//             consecutive cycles of disagreement with the synchronized input
// -----------------------------------------------------------------------------
module debouncer_bit #(
    parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic estavel
);

    localparam int unsigned LARGURA = $clog2(DEBOUNCE_CICLOS);
    localparam logic [LARGURA-1:0] CONTA_FINAL = LARGURA'(DEBOUNCE_CICLOS - 1);

    logic               sinc1;
    logic               sinc2;
    logic               estavel_q;
    logic               estavel_d;
    logic [LARGURA-1:0] contador_q;
    logic [LARGURA-1:0] contador_d;

    // Two-flop synchronizer for the asynchronous pin level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1 <= 1'b0;
            sinc2 <= 1'b0;
        end else begin
            sinc1 <= bruto;
            sinc2 <= sinc1;
        end
    end

    // The counter measures how long sinc2 has disagreed with estavel. Any
    // agreement restarts it, so only an uninterrupted run of
    // DEBOUNCE_CICLOS differing cycles flips the stable value.
    always_comb begin
        estavel_d  = estavel_q;
        contador_d = '0;
        if (sinc2 != estavel_q) begin
            if (contador_q == CONTA_FINAL) begin
                estavel_d  = sinc2;
                contador_d = '0;
            end else begin
                contador_d = contador_q + LARGURA'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estavel_q  <= 1'b0;
            contador_q <= '0;
        end else begin
            estavel_q  <= estavel_d;
            contador_q <= contador_d;
        end
    end

    assign estavel = estavel_q;

endmodule

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Turns the raw panel pushbuttons into clean one-cycle, one-hot press events
// for the memory-game data path.
//
// Ports:
//   clock         : system clock, single domain
//   reset         : synchronous, active-high reset
//   botoes_brutos : raw asynchronous button levels
//   botoes        : one-hot pulse (one cycle) per accepted press, else zero
//   pressionado   : high while an accepted press is still held
//   db_botao      : index of the last accepted button (debug)
// -----------------------------------------------------------------------------
module condicionador_botoes
    import pkg_botoes::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 50000,
    parameter bit          ATIVO_BAIXO     = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes_brutos,
    output logic [NUM_BOTOES-1:0] botoes,
    output logic                  pressionado,
    output logic [2:0]            db_botao
);

    logic [NUM_BOTOES-1:0] entrada;
    logic [NUM_BOTOES-1:0] estavel;

    estado_t               estado_q;
    estado_t               estado_d;
    logic [NUM_BOTOES-1:0] botoes_q;
    logic [NUM_BOTOES-1:0] botoes_d;
    logic [2:0]            db_botao_q;
    logic [2:0]            db_botao_d;
    logic [2:0]            indice;

    // Polarity correction: XOR with the parameter inverts every bit in
    // active-low mode, so downstream logic always sees pressed = 1.
    assign entrada = botoes_brutos ^ {NUM_BOTOES{ATIVO_BAIXO}};

    for (genvar g = 0; g < NUM_BOTOES; g++) begin : g_debounce
        debouncer_bit #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_debouncer_bit (
            .clock  (clock),
            .reset  (reset),
            .bruto  (entrada[g]),
            .estavel(estavel[g])
        );
    end

    assign indice = indice_menor(estavel);

    // Selection FSM: accept one button, then ignore everything until all
    // buttons are released. A button still held on return to OCIOSO is taken
    // as a new press on the following cycle.
    always_comb begin
        estado_d   = estado_q;
        botoes_d   = '0;
        db_botao_d = db_botao_q;
        unique case (estado_q)
            OCIOSO: begin
                if (|estavel) begin
                    botoes_d   = NUM_BOTOES'(1) << indice;
                    db_botao_d = indice;
                    estado_d   = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                if (estavel == '0) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            botoes_q   <= '0;
            db_botao_q <= 3'd0;
        end else begin
            estado_q   <= estado_d;
            botoes_q   <= botoes_d;
            db_botao_q <= db_botao_d;
        end
    end

    // All outputs come straight from flops.
    assign botoes      = botoes_q;
    assign pressionado = (estado_q == ESPERA_SOLTAR);
    assign db_botao    = db_botao_q;

endmodule
